// File: rtl/tag_ram_pkg.sv
// Shared types and constants for the N-way MSI tag/state array.
package tag_ram_pkg;

  localparam int unsigned TWIDTH_DEF = 9;
  localparam int unsigned SWIDTH_DEF = 2;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef struct packed {
    logic [SWIDTH_DEF-1:0] state;
    logic [TWIDTH_DEF-1:0] tag;
  } entry_t;

  typedef enum logic {INIT, RUN} fsm_e;

  function automatic int unsigned way_width(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/tag_way_bank.sv
// One way of the tag array: DEPTH x EWIDTH storage, one write port, asynchronous read.
module tag_way_bank #(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned EWIDTH = 11
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [EWIDTH-1:0] wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [EWIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [EWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tag_ram_nway_init.sv
// N-way MSI tag/state array with post-reset clearing sweep and one-cycle lookup.
// Define TAG_RAM_WR_BYPASS_EN to forward a same-set write into a concurrent lookup.
module tag_ram_nway_init
  import tag_ram_pkg::*;
#(
  parameter  int unsigned AWIDTH = 3,
  parameter  int unsigned TWIDTH = TWIDTH_DEF,
  parameter  int unsigned SWIDTH = SWIDTH_DEF,
  parameter  int unsigned WAYS   = 2,
  localparam int unsigned EWIDTH = SWIDTH + TWIDTH,
  localparam int unsigned WWIDTH = way_width(WAYS)
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   ready,
  input  logic                   lk_valid,
  input  logic [AWIDTH-1:0]      lk_addr,
  input  logic [TWIDTH-1:0]      lk_tag,
  input  logic                   wr_en,
  input  logic [AWIDTH-1:0]      wr_addr,
  input  logic [WWIDTH-1:0]      wr_way,
  input  logic [EWIDTH-1:0]      wr_data,
  output logic                   rs_valid,
  output logic                   rs_hit,
  output logic [WWIDTH-1:0]      rs_way,
  output logic [SWIDTH-1:0]      rs_state,
  output logic [WAYS*EWIDTH-1:0] rs_entries
);

  localparam int unsigned DEPTH  = 1 << AWIDTH;
  localparam int unsigned CWIDTH = AWIDTH + 1;

  fsm_e              state_q, state_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic              rs_valid_q, rs_valid_d;
  logic [TWIDTH-1:0] tag_q, tag_d;
  logic [EWIDTH-1:0] ent_q [WAYS];
  logic [EWIDTH-1:0] ent_d [WAYS];
  logic [EWIDTH-1:0] rd_ent [WAYS];

  logic [WAYS-1:0]   bank_we;
  logic [AWIDTH-1:0] bank_waddr;
  logic [EWIDTH-1:0] bank_wdata;
  logic              accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      rs_valid_q <= 1'b0;
      tag_q      <= '0;
      for (int w = 0; w < WAYS; w++) begin
        ent_q[w] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rs_valid_q <= rs_valid_d;
      tag_q      <= tag_d;
      for (int w = 0; w < WAYS; w++) begin
        ent_q[w] <= ent_d[w];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + CWIDTH'(1);
        if (cnt_q == CWIDTH'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // The sweep owns every bank's write port until the FSM reaches RUN.
  always_comb begin
    ready      = (state_q == RUN);
    accept     = ready & lk_valid;
    bank_we    = '0;
    bank_waddr = wr_addr;
    bank_wdata = wr_data;
    if (state_q == INIT) begin
      bank_we    = {WAYS{1'b1}};
      bank_waddr = cnt_q[AWIDTH-1:0];
      bank_wdata = '0;
    end else if (wr_en) begin
      for (int w = 0; w < WAYS; w++) begin
        bank_we[w] = (wr_way == WWIDTH'(w));
      end
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : gen_way
    tag_way_bank #(
      .AWIDTH (AWIDTH),
      .EWIDTH (EWIDTH)
    ) u_bank (
      .clk_i   (clock),
      .we_i    (bank_we[g]),
      .waddr_i (bank_waddr),
      .wdata_i (bank_wdata),
      .raddr_i (lk_addr),
      .rdata_o (rd_ent[g])
    );
  end

  // The set is captured at accept time, so a same-edge write is naturally read-old.
  always_comb begin
    rs_valid_d = accept;
    tag_d      = accept ? lk_tag : tag_q;
    for (int w = 0; w < WAYS; w++) begin
      ent_d[w] = ent_q[w];
      if (accept) begin
        ent_d[w] = rd_ent[w];
`ifdef TAG_RAM_WR_BYPASS_EN
        if (bank_we[w] && (bank_waddr == lk_addr)) begin
          ent_d[w] = bank_wdata;
        end
`endif
      end
    end
  end

  // Descending scan so the lowest hitting way is the one left standing.
  always_comb begin
    rs_valid = rs_valid_q;
    rs_hit   = 1'b0;
    rs_way   = '0;
    rs_state = SWIDTH'(ST_I);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if ((ent_q[w][EWIDTH-1 -: SWIDTH] != SWIDTH'(ST_I)) &&
          (ent_q[w][TWIDTH-1:0] == tag_q)) begin
        rs_hit   = 1'b1;
        rs_way   = WWIDTH'(w);
        rs_state = ent_q[w][EWIDTH-1 -: SWIDTH];
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      rs_entries[w*EWIDTH +: EWIDTH] = ent_q[w];
    end
  end

endmodule

// File: tb/tb_tag_ram_nway_init.sv
// Randomised and directed bench for tag_ram_nway_init against an array-based model.
module tb_tag_ram_nway_init;
  import tag_ram_pkg::*;

  localparam int unsigned AW    = 3;
  localparam int unsigned TW    = 9;
  localparam int unsigned SW    = 2;
  localparam int unsigned NW    = 2;
  localparam int unsigned EW    = SW + TW;
  localparam int unsigned WW    = 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ready;
  logic             lk_valid = 1'b0;
  logic [AW-1:0]    lk_addr = '0;
  logic [TW-1:0]    lk_tag = '0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WW-1:0]    wr_way = '0;
  logic [EW-1:0]    wr_data = '0;
  logic             rs_valid;
  logic             rs_hit;
  logic [WW-1:0]    rs_way;
  logic [SW-1:0]    rs_state;
  logic [NW*EW-1:0] rs_entries;

  tag_ram_nway_init #(
    .AWIDTH (AW),
    .TWIDTH (TW),
    .SWIDTH (SW),
    .WAYS   (NW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ready      (ready),
    .lk_valid   (lk_valid),
    .lk_addr    (lk_addr),
    .lk_tag     (lk_tag),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_way     (wr_way),
    .wr_data    (wr_data),
    .rs_valid   (rs_valid),
    .rs_hit     (rs_hit),
    .rs_way     (rs_way),
    .rs_state   (rs_state),
    .rs_entries (rs_entries)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0]    model [NW][DEPTH];
  bit               last_hit;
  logic [WW-1:0]    last_way;
  logic [SW-1:0]    last_st;
  logic [NW*EW-1:0] last_ent;

  task automatic check_eq(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < DEPTH; s++) model[w][s] = '0;
    last_hit = 1'b0;
    last_way = '0;
    last_st  = '0;
    last_ent = '0;
  endtask

  task automatic model_lookup(input logic [AW-1:0] a, input logic [TW-1:0] t, output bit hit,
                              output logic [WW-1:0] way, output logic [SW-1:0] st,
                              output logic [NW*EW-1:0] ent);
    entry_t e;
    hit = 1'b0;
    way = '0;
    st  = ST_I;
    ent = '0;
    for (int w = 0; w < NW; w++) begin
      e = model[w][a];
      ent[w*EW +: EW] = e;
      if (!hit && e.state != ST_I && e.tag == t) begin
        hit = 1'b1;
        way = WW'(w);
        st  = e.state;
      end
    end
  endtask

  // One clock of optional write plus optional lookup, then check the result or the hold.
  task automatic do_cycle(input bit do_wr, input logic [AW-1:0] wa, input int unsigned ww,
                          input logic [EW-1:0] wd, input bit do_lk, input logic [AW-1:0] la,
                          input logic [TW-1:0] lt);
    bit               e_hit;
    logic [WW-1:0]    e_way;
    logic [SW-1:0]    e_st;
    logic [NW*EW-1:0] e_ent;
    wr_en    = do_wr;
    wr_addr  = wa;
    wr_way   = WW'(ww);
    wr_data  = wd;
    lk_valid = do_lk;
    lk_addr  = la;
    lk_tag   = lt;
`ifdef TAG_RAM_WR_BYPASS_EN
    if (do_wr && ww < NW) model[ww][wa] = wd;
    model_lookup(la, lt, e_hit, e_way, e_st, e_ent);
`else
    model_lookup(la, lt, e_hit, e_way, e_st, e_ent);
    if (do_wr && ww < NW) model[ww][wa] = wd;
`endif
    step();
    wr_en    = 1'b0;
    lk_valid = 1'b0;
    if (do_lk) begin
      last_hit = e_hit;
      last_way = e_way;
      last_st  = e_st;
      last_ent = e_ent;
      check_eq("rs_valid", rs_valid, 1);
    end else begin
      check_eq("rs_valid_idle", rs_valid, 0);
    end
    check_eq("rs_hit", rs_hit, last_hit);
    check_eq("rs_way", rs_way, last_way);
    check_eq("rs_state", rs_state, last_st);
    check_eq("rs_entries", rs_entries, last_ent);
  endtask

  // Reset has just been released; requests during the sweep must be ignored.
  task automatic sweep_check();
    for (int k = 0; k < DEPTH; k++) begin
      check_eq("sweep_ready_low", ready, 0);
      check_eq("sweep_rs_valid", rs_valid, 0);
      lk_valid = 1'b1;
      lk_addr  = AW'($urandom_range(0, DEPTH - 1));
      lk_tag   = '0;
      wr_en    = 1'b1;
      wr_addr  = AW'(k);
      wr_way   = WW'($urandom_range(0, NW - 1));
      wr_data  = {ST_M, TW'(0)};
      step();
    end
    lk_valid = 1'b0;
    wr_en    = 1'b0;
    check_eq("sweep_ready_high", ready, 1);
    clear_model();
  endtask

  initial begin
    clear_model();
    reset = 1'b1;
    repeat (3) step();
    check_eq("reset_ready", ready, 0);
    check_eq("reset_rs_valid", rs_valid, 0);
    check_eq("reset_rs_hit", rs_hit, 0);
    check_eq("reset_rs_way", rs_way, 0);
    check_eq("reset_rs_state", rs_state, 0);
    reset = 1'b0;
    sweep_check();

    for (int s = 0; s < DEPTH; s++) do_cycle(0, '0, 0, '0, 1, AW'(s), '0);

    do_cycle(1, 3'd5, 1, {ST_S, 9'h0A3}, 0, '0, '0);
    do_cycle(0, '0, 0, '0, 1, 3'd5, 9'h0A3);
    check_eq("fill_hit", rs_hit, 1);
    check_eq("fill_way", rs_way, 1);
    check_eq("fill_state", rs_state, ST_S);
    do_cycle(1, 3'd5, 1, {ST_M, 9'h0A3}, 0, '0, '0);
    check_eq("hold_state", rs_state, ST_S);
    do_cycle(1, 3'd5, 1, {ST_S, 9'h0A3}, 1, 3'd5, 9'h0A4);
    check_eq("fill_miss", rs_hit, 0);

    do_cycle(1, 3'd2, 0, {ST_I, 9'h011}, 0, '0, '0);
    do_cycle(0, '0, 0, '0, 1, 3'd2, 9'h011);
    check_eq("inv_nohit", rs_hit, 0);
    check_eq("inv_entry", rs_entries[EW-1:0], 11'h011);

    do_cycle(1, 3'd3, 0, {ST_M, 9'h055}, 0, '0, '0);
    do_cycle(1, 3'd3, 1, {ST_M, 9'h055}, 0, '0, '0);
    do_cycle(0, '0, 0, '0, 1, 3'd3, 9'h055);
    check_eq("dup_way", rs_way, 0);
    check_eq("dup_state", rs_state, ST_M);

    do_cycle(1, 3'd4, 0, {ST_S, 9'h007}, 0, '0, '0);
    do_cycle(1, 3'd4, 0, {ST_M, 9'h007}, 1, 3'd4, 9'h007);
`ifdef TAG_RAM_WR_BYPASS_EN
    check_eq("same_cycle_state", rs_state, ST_M);
`else
    check_eq("same_cycle_state", rs_state, ST_S);
`endif
    do_cycle(0, '0, 0, '0, 1, 3'd4, 9'h007);
    check_eq("after_write_state", rs_state, ST_M);

    for (int i = 0; i < 300; i++) begin
      do_cycle(bit'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
               $urandom_range(0, NW - 1),
               {SW'($urandom_range(0, 3)), TW'($urandom_range(0, 3))},
               bit'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
               TW'($urandom_range(0, 3)));
    end

    do_cycle(1, 3'd5, 1, {ST_S, 9'h0A3}, 0, '0, '0);
    do_cycle(0, '0, 0, '0, 1, 3'd5, 9'h0A3);
    check_eq("pre_reset_hit", rs_hit, 1);
    reset    = 1'b1;
    lk_valid = 1'b1;
    lk_addr  = 3'd5;
    lk_tag   = 9'h0A3;
    step();
    check_eq("midreset_rs_valid", rs_valid, 0);
    check_eq("midreset_rs_hit", rs_hit, 0);
    check_eq("midreset_ready", ready, 0);
    reset    = 1'b0;
    lk_valid = 1'b0;
    sweep_check();
    do_cycle(0, '0, 0, '0, 1, 3'd5, 9'h0A3);
    check_eq("post_reset_miss", rs_hit, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
